// File: rtl/project_selector.sv
// project_selector: Wishbone-controlled one-hot project enable with guarded switching; optional macro PROJECT_SELECTOR_LA_OVERRIDE_EN
module project_selector #(
  parameter int          NUM_PROJECTS = 6,
  parameter int          GUARD_CYCLES = 16,
  parameter logic [31:0] BASE_ADDR    = 32'h3000_0000
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_dat_i,
  input  logic [31:0] wbs_adr_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  input  logic [31:0] la_data_in,
  output logic [31:0] active,
  output logic        busy
);
  typedef enum logic [1:0] {OFF = 2'd0, GUARD = 2'd1, ON = 2'd2} state_t;
  state_t      r_state, w_next;
  logic        r_ack, r_we, r_pend_en, r_cur_en, r_err;
  logic [1:0]  r_off, r_sel;
  logic [5:0]  r_dat;
  logic [4:0]  r_pend_idx, r_cur_idx;
  logic [7:0]  r_cnt;
  logic [15:0] r_count;
  logic        w_hit, w_sel_wr, w_cnt_wr, w_done, w_valid, w_unused;
  logic [31:0] w_rdata, w_fsm_active;
  assign w_hit    = wbs_stb_i & wbs_cyc_i & (wbs_adr_i[31:4] == BASE_ADDR[31:4]) & ~r_ack;
  assign w_sel_wr = r_ack & r_we & (r_off == 2'd0);
  assign w_cnt_wr = r_ack & r_we & (r_off == 2'd2);
  assign w_done   = (r_state == GUARD) & (r_cnt == 8'd0) & ~w_sel_wr;
  assign w_valid  = r_pend_en & (int'(r_pend_idx) < NUM_PROJECTS);
  assign busy     = (r_state == GUARD);
  assign w_rdata  = (r_off == 2'd0) ? {23'd0, r_pend_en, 3'd0, r_pend_idx} :
                    (r_off == 2'd1) ? {6'd0, r_state, 6'd0, r_err, busy, 7'd0, r_cur_en, 3'd0, r_cur_idx} :
                    (r_off == 2'd2) ? {16'd0, r_count} : 32'd0;
  assign wbs_ack_o    = r_ack;
  assign wbs_dat_o    = (r_ack & ~r_we) ? w_rdata : 32'd0;
  assign w_fsm_active = (r_state == ON) ? (32'd1 << r_cur_idx) : 32'd0;
`ifdef PROJECT_SELECTOR_LA_OVERRIDE_EN
  assign active   = la_data_in[31] ? ({1'b0, la_data_in[30:0]} & ((32'd1 << NUM_PROJECTS) - 32'd1)) : w_fsm_active;
  assign w_unused = &{1'b0, wbs_adr_i[1:0], wbs_dat_i[31:9], wbs_dat_i[7:5], wbs_sel_i[3:2]};
`else
  assign active   = w_fsm_active;
  assign w_unused = &{1'b0, la_data_in, wbs_adr_i[1:0], wbs_dat_i[31:9], wbs_dat_i[7:5], wbs_sel_i[3:2]};
`endif
  // SELECT writes restart the dead time from any state; guard expiry lands in ON or OFF
  always_comb begin
    w_next = w_sel_wr ? GUARD : w_done ? (w_valid ? ON : OFF) : r_state;
  end
  // state register
  always_ff @(posedge wb_clk_i) begin
    r_state <= wb_rst_i ? OFF : w_next;
  end
  // bus capture, ack generation and register-file updates applied in the ack cycle
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_ack      <= 1'b0;
      r_we       <= 1'b0;
      r_off      <= 2'd0;
      r_sel      <= 2'd0;
      r_dat      <= 6'd0;
      r_pend_idx <= 5'd0;
      r_pend_en  <= 1'b0;
      r_cur_idx  <= 5'd0;
      r_cur_en   <= 1'b0;
      r_err      <= 1'b0;
      r_cnt      <= 8'd0;
      r_count    <= 16'd0;
    end else begin
      r_ack <= w_hit;
      if (w_hit) begin
        r_we  <= wbs_we_i;
        r_off <= wbs_adr_i[3:2];
        r_sel <= wbs_sel_i[1:0];
        r_dat <= {wbs_dat_i[8], wbs_dat_i[4:0]};
      end
      if (w_sel_wr && r_sel[0]) r_pend_idx <= r_dat[4:0];
      if (w_sel_wr && r_sel[1]) r_pend_en <= r_dat[5];
      r_cnt <= w_sel_wr ? 8'(GUARD_CYCLES - 1) : r_cnt - {7'd0, busy};
      if (w_done) begin
        r_cur_idx <= r_pend_idx;
        r_cur_en  <= r_pend_en;
      end
      r_count <= w_cnt_wr ? 16'd0 : r_count + {15'd0, w_done};
      r_err   <= w_cnt_wr ? 1'b0 : (r_err | (w_done & r_pend_en & ~w_valid));
    end
  end
endmodule

// File: doc/project_selector.md
PROJECT_SELECTOR -- requirements
Module: project_selector

Interface
REQ-001 SHALL have parameter NUM_PROJECTS, default 6, number of selectable projects (1..31).
REQ-002 SHALL have parameter GUARD_CYCLES, default 16, all-off dead time between project switches (2..255).
REQ-003 SHALL have parameter BASE_ADDR, default 32'h3000_0000, Wishbone register block base.
REQ-004 SHALL have port wb_clk_i  in  1  sole clock, all logic on rising edge.
REQ-005 SHALL have port wb_rst_i  in  1  synchronous, active-high reset.
REQ-006 SHALL have ports wbs_stb_i, wbs_cyc_i, wbs_we_i  in  1 each  Wishbone slave strobe, cycle, write-enable.
REQ-007 SHALL have ports wbs_sel_i  in  4, wbs_dat_i  in  32, wbs_adr_i  in  32  byte selects, write data, address.
REQ-008 SHALL have ports wbs_ack_o  out  1, wbs_dat_o  out  32  acknowledge, read data.
REQ-009 SHALL have port la_data_in  in  32  logic-analyser debug override input.
REQ-010 SHALL have port active  out  32  per-project enable, feeds the active inputs of the wrapped projects.
REQ-011 SHALL have port busy  out  1  high while a switch is in progress (GUARD state).

Function
REQ-012 SHALL decode a hit when wbs_stb_i & wbs_cyc_i & (wbs_adr_i[31:4] == BASE_ADDR[31:4]); non-hits are ignored, no ack.
REQ-013 SHALL assert wbs_ack_o for exactly one cycle, the cycle after a hit, and not re-acknowledge while wbs_ack_o is high (back-to-back accesses ack every other cycle).
REQ-014 SHALL map offset 0x0 SELECT (rw): [4:0] requested index, [8] enable; writes honour wbs_sel_i[0] for [4:0] and wbs_sel_i[1] for [8].
REQ-015 SHALL map offset 0x4 STATUS (ro): [4:0] current index, [8] current enable, [16] busy, [17] sticky error, [25:24] FSM state code.
REQ-016 SHALL map offset 0x8 COUNT (ro): [15:0] completed-switch counter, wrapping 0xFFFF -> 0x0000; write to 0x8 clears it and sticky error.
REQ-017 SHALL return 0 on read of offset 0xC, ignore writes there, and still acknowledge.
REQ-018 SHALL drive wbs_dat_o with read data in the ack cycle only, 0 otherwise.
REQ-019 SHALL implement FSM states OFF (code 0), GUARD (code 1), ON (code 2).
REQ-020 SHALL in OFF and GUARD drive active = 0; in ON drive active = 1 << current index (exactly one bit).
REQ-021 SHALL, on any write to SELECT, latch the pending index/enable and enter GUARD with guard counter loaded to GUARD_CYCLES-1, from any state.
REQ-022 SHALL, on a SELECT write while already in GUARD, overwrite pending values and reload the guard counter (restart dead time).
REQ-023 SHALL in GUARD decrement the counter each cycle; at counter 0 move pending to current and go to ON if enable=1 and index < NUM_PROJECTS, else OFF.
REQ-024 SHALL, when enable=1 and index >= NUM_PROJECTS at guard end, go to OFF and set sticky error.
REQ-025 SHALL increment COUNT by 1 on every GUARD exit, whether to ON or OFF.
REQ-026 SHALL give latency: write ack at cycle N; GUARD entered cycle N+1; active bit high at cycle N+1+GUARD_CYCLES.
REQ-027 SHALL assert busy exactly while in GUARD.

Reset
REQ-028 SHALL on wb_rst_i high at a clock edge force state OFF, active = 0, busy = 0, wbs_ack_o = 0, wbs_dat_o = 0, current/pending index 0, enable 0, COUNT 0, error 0.
REQ-029 SHALL abort any in-progress switch or bus access on reset; a hit coincident with reset is not acknowledged.

Configuration
REQ-030 SHALL support macro PROJECT_SELECTOR_LA_OVERRIDE_EN.
REQ-031 SHALL, with PROJECT_SELECTOR_LA_OVERRIDE_EN defined and la_data_in[31] = 1, drive active = {1'b0, la_data_in[30:0]} masked to NUM_PROJECTS bits, bypassing the FSM output; FSM and registers keep running.
REQ-032 SHALL, without PROJECT_SELECTOR_LA_OVERRIDE_EN, ignore la_data_in entirely (active driven only by FSM).

Verification
REQ-033 SHALL cover: reset, write SELECT=0x103 -> ack next cycle, busy 16 cycles, then active=0x0000_0008, COUNT=1.
REQ-034 SHALL cover: in ON idx 3, write SELECT=0x101 -> active=0 next cycle, 16 cycles later active=0x0000_0002, never two bits high.
REQ-035 SHALL cover: write SELECT=0x102, then SELECT=0x104 after 5 guard cycles -> guard restarts, active=0x10 at 16 cycles after second ack, COUNT incremented once.
REQ-036 SHALL cover: write SELECT=0x11F -> after guard state OFF, active=0, STATUS[17]=1; write 0x8 -> STATUS[17]=0, COUNT=0.
REQ-037 SHALL cover: assert wb_rst_i mid-GUARD -> next cycle active=0, busy=0, STATUS read = 0.
REQ-038 SHALL cover (macro defined): la_data_in=0x8000_0021 -> active=0x0000_0021 same cycle-registered path; la_data_in[31]=0 -> FSM value restored.
